// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Stall/flush controller for the 5-stage MIPS pipeline. It catches the hazards
// that operand forwarding cannot cover:
//   - load-use: the EX instruction is a load that feeds an ID source.
//   - ID-stage branch compare: the branch needs a result still in EX, or a
//     load result still in MEM.
//   - HI/LO access or a new mult/div while the multi-cycle MULT/DIV unit is
//     busy.
// It also launches MULT/DIV operations and counts stall cycles.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ID_rs, ID_rt            source fields of the instruction in ID
//   ID_uses_rt              ID instruction actually reads rt
//   ID_branch               ID instruction is beq/bne
//   ID_branch_taken         ID compare result
//   ID_muldiv               ID instruction is mult/multu/div/divu
//   ID_reads_hilo           ID instruction is mfhi/mflo
//   EX_MemRead, EX_RegWrite, EX_write_register    EX stage producer info
//   MEM_MemRead, MEM_write_register               MEM stage producer info
//   PC_write, IF_ID_write   front-end write enables (0 = hold)
//   ID_EX_bubble            insert NOP control into ID/EX
//   IF_ID_flush             squash the fetched instruction (taken branch)
//   md_start                one-cycle MULT/DIV launch pulse
//   md_busy                 MULT/DIV in progress (registered state)
//   stall_count             saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int MD_CYCLES   = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             ID_rs,
    input  logic [4:0]             ID_rt,
    input  logic                   ID_uses_rt,
    input  logic                   ID_branch,
    input  logic                   ID_branch_taken,
    input  logic                   ID_muldiv,
    input  logic                   ID_reads_hilo,
    input  logic                   EX_MemRead,
    input  logic                   EX_RegWrite,
    input  logic [4:0]             EX_write_register,
    input  logic                   MEM_MemRead,
    input  logic [4:0]             MEM_write_register,
    output logic                   PC_write,
    output logic                   IF_ID_write,
    output logic                   ID_EX_bubble,
    output logic                   IF_ID_flush,
    output logic                   md_start,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    md_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0]  stall_count_q, stall_count_d;

    logic load_use;
    logic br_ex;
    logic br_mem;
    logic md_hazard;
    logic stall;
    logic md_start_c;

    // $zero is never a real dependency; rt only counts when it is a source.
    function automatic logic match(input logic [4:0] r,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign md_busy     = (state_q == MD_BUSY);
    assign stall_count = stall_count_q;

    always_comb begin
        load_use  = EX_MemRead & match(EX_write_register, ID_rs, ID_rt, ID_uses_rt);
        br_ex     = ID_branch & EX_RegWrite & match(EX_write_register, ID_rs, ID_rt, ID_uses_rt);
        br_mem    = ID_branch & MEM_MemRead & match(MEM_write_register, ID_rs, ID_rt, ID_uses_rt);
        md_hazard = md_busy & (ID_reads_hilo | ID_muldiv);
        stall     = load_use | br_ex | br_mem | md_hazard;
    end

    // MULT/DIV sequencer. The count is loaded with MD_CYCLES-1 on launch so
    // the unit reports busy for exactly MD_CYCLES-1 cycles after the start
    // cycle; an mfhi/mflo in the cycle it drops back to idle goes through.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_start_c = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (ID_muldiv && !stall) begin
                    md_start_c = 1'b1;
                    cnt_d      = CNT_W'(MD_CYCLES - 1);
                    state_d    = MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline control. While reset is held the front end runs freely and
    // nothing is launched. A branch only flushes once it actually leaves ID,
    // so its resolution is ignored during a stall.
    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        md_start     = 1'b0;
        if (rst_n) begin
            md_start = md_start_c;
            if (stall) begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end else begin
                IF_ID_flush = ID_branch & ID_branch_taken;
            end
        end
    end

    // Saturating stall counter: sticks at all-ones instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MD_IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Self-checking bench for hazard_stall_unit with MD_CYCLES=4 and a 4-bit
// stall counter, so saturation is reachable in a short run. Each vector is
// one clock cycle: inputs are driven after the falling edge, the expected
// record is queued, and outputs are compared shortly afterwards, before the
// next rising edge. stall_count is tracked by a small saturating model.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int MD_CYCLES   = 4;
    localparam int STALL_CNT_W = 4;
    localparam int CNT_MAX     = (1 << STALL_CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic [4:0]             ID_rs;
    logic [4:0]             ID_rt;
    logic                   ID_uses_rt;
    logic                   ID_branch;
    logic                   ID_branch_taken;
    logic                   ID_muldiv;
    logic                   ID_reads_hilo;
    logic                   EX_MemRead;
    logic                   EX_RegWrite;
    logic [4:0]             EX_write_register;
    logic                   MEM_MemRead;
    logic [4:0]             MEM_write_register;
    logic                   PC_write;
    logic                   IF_ID_write;
    logic                   ID_EX_bubble;
    logic                   IF_ID_flush;
    logic                   md_start;
    logic                   md_busy;
    logic [STALL_CNT_W-1:0] stall_count;

    hazard_stall_unit #(
        .MD_CYCLES   (MD_CYCLES),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ID_rs              (ID_rs),
        .ID_rt              (ID_rt),
        .ID_uses_rt         (ID_uses_rt),
        .ID_branch          (ID_branch),
        .ID_branch_taken    (ID_branch_taken),
        .ID_muldiv          (ID_muldiv),
        .ID_reads_hilo      (ID_reads_hilo),
        .EX_MemRead         (EX_MemRead),
        .EX_RegWrite        (EX_RegWrite),
        .EX_write_register  (EX_write_register),
        .MEM_MemRead        (MEM_MemRead),
        .MEM_write_register (MEM_write_register),
        .PC_write           (PC_write),
        .IF_ID_write        (IF_ID_write),
        .ID_EX_bubble       (ID_EX_bubble),
        .IF_ID_flush        (IF_ID_flush),
        .md_start           (md_start),
        .md_busy            (md_busy),
        .stall_count        (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       branch;
        logic       taken;
        logic       muldiv;
        logic       reads_hilo;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_wr;
        logic       mem_mr;
        logic [4:0] mem_wr;
        logic       exp_stall;
        logic       exp_flush;
        logic       exp_start;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   cycle_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        ID_rs              = v.rs;
        ID_rt              = v.rt;
        ID_uses_rt         = v.uses_rt;
        ID_branch          = v.branch;
        ID_branch_taken    = v.taken;
        ID_muldiv          = v.muldiv;
        ID_reads_hilo      = v.reads_hilo;
        EX_MemRead         = v.ex_mr;
        EX_RegWrite        = v.ex_rw;
        EX_write_register  = v.ex_wr;
        MEM_MemRead        = v.mem_mr;
        MEM_write_register = v.mem_wr;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveInputs(v);
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        #2;
        cycle_no++;
        if (sb.size() == 0) begin
            check($sformatf("c%0d scoreboard_empty", cycle_no), 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check($sformatf("c%0d PC_write", cycle_no),     32'(PC_write),     32'(!e.exp_stall));
        check($sformatf("c%0d IF_ID_write", cycle_no),  32'(IF_ID_write),  32'(!e.exp_stall));
        check($sformatf("c%0d ID_EX_bubble", cycle_no), 32'(ID_EX_bubble), 32'(e.exp_stall));
        check($sformatf("c%0d IF_ID_flush", cycle_no),  32'(IF_ID_flush),  32'(e.exp_flush));
        check($sformatf("c%0d md_start", cycle_no),     32'(md_start),     32'(e.exp_start));
        check($sformatf("c%0d md_busy", cycle_no),      32'(md_busy),      32'(e.exp_busy));
        check($sformatf("c%0d stall_count", cycle_no),  32'(stall_count),  32'(model_cnt));
        if (e.exp_stall && model_cnt < CNT_MAX) model_cnt++;
    endtask

    task automatic runCycle(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    // Field order: rs rt uses_rt branch taken muldiv reads_hilo ex_mr ex_rw
    //              ex_wr mem_mr mem_wr | stall flush start busy
    localparam vec_t IDLE_V = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic vec_t mk_idle(input logic busy);
        vec_t v = IDLE_V;
        v.exp_busy = busy;
        return v;
    endfunction

    function automatic vec_t mk_md(input logic muldiv, input logic hilo,
                                   input logic stall, input logic start, input logic busy);
        vec_t v = IDLE_V;
        v.muldiv     = muldiv;
        v.reads_hilo = hilo;
        v.exp_stall  = stall;
        v.exp_start  = start;
        v.exp_busy   = busy;
        return v;
    endfunction

    initial begin
        vec_t v;

        // Independent single-cycle vectors, FSM idle throughout.
        vecs.push_back(IDLE_V);
        vecs.push_back('{5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Reset state: stall-inducing inputs must not affect forced outputs.
        rst_n = 1'b0;
        v = vecs[1];
        v.muldiv = 1'b1;
        driveInputs(v);
        #12;
        check("reset PC_write", 32'(PC_write), 32'd1);
        check("reset IF_ID_write", 32'(IF_ID_write), 32'd1);
        check("reset ID_EX_bubble", 32'(ID_EX_bubble), 32'd0);
        check("reset IF_ID_flush", 32'(IF_ID_flush), 32'd0);
        check("reset md_start", 32'(md_start), 32'd0);
        check("reset md_busy", 32'(md_busy), 32'd0);
        check("reset stall_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        driveInputs(IDLE_V);
        rst_n = 1'b1;

        $display("[TB] table vectors");
        foreach (vecs[i]) runCycle(vecs[i]);

        $display("[TB] load then dependent taken branch");
        runCycle('{5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        runCycle('{5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0});
        runCycle('{5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        runCycle(mk_idle(1'b0));

        $display("[TB] mult then mflo");
        runCycle(mk_md(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < MD_CYCLES - 1; i++) runCycle(mk_md(1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        runCycle(mk_md(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        $display("[TB] back-to-back mult/div");
        runCycle(mk_md(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < MD_CYCLES - 1; i++) runCycle(mk_md(1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        runCycle(mk_md(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < MD_CYCLES - 1; i++) runCycle(mk_idle(1'b1));
        runCycle(mk_idle(1'b0));

        $display("[TB] mult blocked by load-use");
        v = vecs[1];
        v.muldiv = 1'b1;
        runCycle(v);
        runCycle(mk_idle(1'b0));

        $display("[TB] stall counter saturation");
        for (int i = 0; i < 5; i++) runCycle(vecs[1]);
        runCycle(mk_idle(1'b0));
        check("saturated stall_count", 32'(stall_count), 32'(CNT_MAX));

        $display("[TB] reset during mult/div");
        runCycle(mk_md(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        runCycle(mk_idle(1'b1));
        @(negedge clk);
        v = vecs[1];
        v.muldiv = 1'b1;
        driveInputs(v);
        rst_n = 1'b0;
        #1;
        check("async md_busy", 32'(md_busy), 32'd0);
        check("async stall_count", 32'(stall_count), 32'd0);
        check("async PC_write", 32'(PC_write), 32'd1);
        check("async ID_EX_bubble", 32'(ID_EX_bubble), 32'd0);
        check("async md_start", 32'(md_start), 32'd0);
        @(negedge clk);
        driveInputs(IDLE_V);
        rst_n = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < MD_CYCLES; i++) runCycle(mk_idle(1'b0));

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
